node_port: RTL and testbench

- Node-side endpoint of the router-core node interface. It drives Packet_From_Node/Packet_From_Node_Valid toward router_core and consumes Core_Load_Ack.
- It captures Packet_To_Node/Packet_To_Node_Valid from router_core and buffers them for the local processor.
- It sits between a processor node and its router_core, in the Clk_R domain.
- It decouples the processor from token latency with a TX FIFO and an RX FIFO.

---
 rtl/node_port.sv | 175 +++++++++++++++++
 tb/tb_node_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_port.sv
// node_port: processor-side endpoint of the router_core node interface.
// Outgoing requests are queued in a TX FIFO and presented to router_core one
// at a time with a valid/level-ack handshake. Incoming deliveries are detected
// on the rising edge of Packet_To_Node_Valid and queued in an RX FIFO.
module node_port #(
  parameter logic [3:0] NODE_ADDR   = 4'd0,
  parameter int         TX_DEPTH    = 4,   // power of 2, >= 2
  parameter int         RX_DEPTH    = 2,   // power of 2, >= 2
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic        Clk_R,
  input  logic        Rst,
  input  logic        Tx_Req_Valid,
  output logic        Tx_Req_Ready,
  input  logic [3:0]  Tx_Req_Dest,
  input  logic        Tx_Req_Type,
  input  logic [23:0] Tx_Req_Data,
  output logic        Tx_Req_Err,
  output logic [28:0] Packet_From_Node,
  output logic        Packet_From_Node_Valid,
  input  logic        Core_Load_Ack,
  input  logic [23:0] Packet_To_Node,
  input  logic        Packet_To_Node_Valid,
  output logic [23:0] Rx_Data,
  output logic        Rx_Valid,
  input  logic        Rx_Ready,
  output logic [7:0]  Rx_Drop_Cnt,
  output logic        Tx_Timeout,
  output logic [2:0]  Tx_Pending
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int TOW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
  localparam logic [TOW-1:0] TO_MAX      = TOW'(ACK_TIMEOUT);
  localparam logic [TOW-1:0] TO_LAST     = TOW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESENT      = 2'd1,
    S_WAIT_ACK_LOW = 2'd2
  } tx_state_e;

  // ---------------- TX FIFO ----------------
  logic [28:0]    tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TCW-1:0] tx_count;
  logic           tx_push, tx_pop, tx_load, tx_self;
  tx_state_e      state, next_state;
  logic [TOW-1:0] to_cnt;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign Tx_Req_Ready = (tx_count != TX_FULL_CNT);
  assign tx_self      = Tx_Req_Valid && Tx_Req_Ready && (Tx_Req_Dest == NODE_ADDR);
  assign tx_push      = Tx_Req_Valid && Tx_Req_Ready && (Tx_Req_Dest != NODE_ADDR);
  assign Tx_Pending   = 3'(tx_count);

  // TX pointers, occupancy and the self-address error pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      Tx_Req_Err <= 1'b0;
    end else begin
      Tx_Req_Err <= tx_self;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + TCW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - TCW'(1);
    end
  end

  // TX storage write.
  // NOTE: FIFO storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge Clk_R) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {Tx_Req_Dest, Tx_Req_Type, Tx_Req_Data};
  end

  // TX handshake state register.
  always_ff @(posedge Clk_R) begin
    if (Rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // TX next-state logic: load in IDLE, pop on ack in PRESENT, wait for ack low.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((tx_count != '0) && !Core_Load_Ack) begin
          tx_load    = 1'b1;
          next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (Core_Load_Ack) begin
          tx_pop     = 1'b1;
          next_state = S_WAIT_ACK_LOW;
        end
      end
      S_WAIT_ACK_LOW: begin
        if (!Core_Load_Ack) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign Packet_From_Node_Valid = (state == S_PRESENT);

  // Presented packet register and sticky ack-timeout tracking.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      Packet_From_Node <= '0;
      to_cnt           <= '0;
      Tx_Timeout       <= 1'b0;
    end else begin
      if (tx_load) Packet_From_Node <= tx_mem[tx_rd_ptr];
      if ((state == S_PRESENT) && !Core_Load_Ack) begin
        if (to_cnt != TO_MAX)  to_cnt <= to_cnt + TOW'(1);
        if (to_cnt == TO_LAST) Tx_Timeout <= 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [23:0]    rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RCW-1:0] rx_count;
  logic           rx_prev, rx_deliver, rx_full, rx_push, rx_pop, rx_drop;

  assign rx_deliver = Packet_To_Node_Valid && !rx_prev;
  assign rx_full    = (rx_count == RX_FULL_CNT);
  assign Rx_Valid   = (rx_count != '0);
  assign rx_pop     = Rx_Valid && Rx_Ready;
  assign rx_push    = rx_deliver && (!rx_full || rx_pop);
  assign rx_drop    = rx_deliver && rx_full && !rx_pop;
  assign Rx_Data    = Rx_Valid ? rx_mem[rx_rd_ptr] : '0;

  // RX edge detect, pointers, occupancy and saturating drop counter.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      rx_prev     <= 1'b0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      Rx_Drop_Cnt <= '0;
    end else begin
      rx_prev <= Packet_To_Node_Valid;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + RCW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - RCW'(1);
      if (rx_drop && (Rx_Drop_Cnt != 8'hFF)) Rx_Drop_Cnt <= Rx_Drop_Cnt + 8'd1;
    end
  end

  // RX storage write.
  always_ff @(posedge Clk_R) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= Packet_To_Node;
  end

endmodule

// File: tb/tb_node_port.sv
// Testbench for node_port: directed stimulus with expected packets queued in
// scoreboards; independent monitors compare TX presentations and RX pops.
module tb_node_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_req_valid;
  logic        tx_req_ready;
  logic [3:0]  tx_req_dest;
  logic        tx_req_type;
  logic [23:0] tx_req_data;
  logic        tx_req_err;
  logic [28:0] pkt_from_node;
  logic        pkt_from_node_valid;
  logic        core_load_ack;
  logic [23:0] pkt_to_node;
  logic        pkt_to_node_valid;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_drop_cnt;
  logic        tx_timeout;
  logic [2:0]  tx_pending;

  int n_checks = 0;
  int n_fails  = 0;
  int tx_edges = 0;

  logic [28:0] tx_exp[$];
  logic [23:0] rx_exp[$];

  node_port dut (
    .Clk_R                 (clk),
    .Rst                   (rst),
    .Tx_Req_Valid          (tx_req_valid),
    .Tx_Req_Ready          (tx_req_ready),
    .Tx_Req_Dest           (tx_req_dest),
    .Tx_Req_Type           (tx_req_type),
    .Tx_Req_Data           (tx_req_data),
    .Tx_Req_Err            (tx_req_err),
    .Packet_From_Node      (pkt_from_node),
    .Packet_From_Node_Valid(pkt_from_node_valid),
    .Core_Load_Ack         (core_load_ack),
    .Packet_To_Node        (pkt_to_node),
    .Packet_To_Node_Valid  (pkt_to_node_valid),
    .Rx_Data               (rx_data),
    .Rx_Valid              (rx_valid),
    .Rx_Ready              (rx_ready),
    .Rx_Drop_Cnt           (rx_drop_cnt),
    .Tx_Timeout            (tx_timeout),
    .Tx_Pending            (tx_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [3:0] dest, input logic typ, input logic [23:0] data);
    tx_req_valid = 1'b1;
    tx_req_dest  = dest;
    tx_req_type  = typ;
    tx_req_data  = data;
    cyc(1);
    tx_req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (pkt_from_node_valid) break;
      cyc(1);
    end
    check(name, 32'(pkt_from_node_valid), 32'd1);
  endtask

  // Single-cycle ack, then let the FSM pass through WAIT_ACK_LOW back to IDLE.
  task automatic ack_pulse();
    core_load_ack = 1'b1;
    cyc(1);
    core_load_ack = 1'b0;
    cyc(2);
  endtask

  task automatic deliver(input logic [23:0] data);
    pkt_to_node       = data;
    pkt_to_node_valid = 1'b1;
    cyc(1);
    pkt_to_node_valid = 1'b0;
    cyc(1);
  endtask

  // TX monitor: each Valid rising edge must present the next expected packet.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pkt_from_node_valid && !prev) begin
        tx_edges++;
        if (tx_exp.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL tx_unexpected: got packet %0h, expected none", pkt_from_node);
        end else begin
          check("tx_packet", 32'(pkt_from_node), 32'(tx_exp.pop_front()));
        end
      end
      prev = pkt_from_node_valid;
    end
  end

  // RX monitor: each processor pop must yield the next expected payload.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready && !rst) begin
        if (rx_exp.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL rx_unexpected: got data %0h, expected none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    rst               = 1'b1;
    tx_req_valid      = 1'b0;
    tx_req_dest       = '0;
    tx_req_type       = 1'b0;
    tx_req_data       = '0;
    core_load_ack     = 1'b0;
    pkt_to_node       = '0;
    pkt_to_node_valid = 1'b0;
    rx_ready          = 1'b0;
    cyc(2);

    // Reset values
    check("rst_ready",   32'(tx_req_ready),        32'd1);
    check("rst_pkt",     32'(pkt_from_node),       32'd0);
    check("rst_valid",   32'(pkt_from_node_valid), 32'd0);
    check("rst_err",     32'(tx_req_err),          32'd0);
    check("rst_rxvalid", 32'(rx_valid),            32'd0);
    check("rst_rxdata",  32'(rx_data),             32'd0);
    check("rst_drop",    32'(rx_drop_cnt),         32'd0);
    check("rst_timeout", 32'(tx_timeout),          32'd0);
    check("rst_pending", 32'(tx_pending),          32'd0);
    rst = 1'b0;
    cyc(1);

    // Basic send: Dest=1 Type=0 Data=42
    tx_exp.push_back(29'h0200002A);
    push_req(4'd1, 1'b0, 24'd42);
    check("basic_pending1", 32'(tx_pending), 32'd1);
    wait_valid("basic_valid");
    cyc(1);
    ack_pulse();
    check("basic_valid_low", 32'(pkt_from_node_valid), 32'd0);
    check("basic_pending0",  32'(tx_pending),          32'd0);

    // Long ack loads only one packet
    snap = tx_edges;
    tx_exp.push_back(29'h0200002A);
    tx_exp.push_back(29'h04000064);
    push_req(4'd1, 1'b0, 24'd42);
    push_req(4'd2, 1'b0, 24'd100);
    wait_valid("long_valid1");
    core_load_ack = 1'b1;
    cyc(10);
    check("long_valid_held_low", 32'(pkt_from_node_valid), 32'd0);
    check("long_pending1",       32'(tx_pending),          32'd1);
    core_load_ack = 1'b0;
    wait_valid("long_valid2");
    ack_pulse();
    check("long_edges", 32'(tx_edges - snap), 32'd2);

    // Backpressure: fifth request refused
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("bp_ready_%0d", k), 32'(tx_req_ready), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) tx_exp.push_back(29'h07000000 | 29'(k));
      tx_req_valid = 1'b1;
      tx_req_dest  = 4'd3;
      tx_req_type  = 1'b1;
      tx_req_data  = 24'(k);
      cyc(1);
    end
    tx_req_valid = 1'b0;
    check("bp_pending4", 32'(tx_pending),   32'd4);
    check("bp_ready0",   32'(tx_req_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      wait_valid($sformatf("bp_valid_%0d", k));
      ack_pulse();
    end
    check("bp_pending0", 32'(tx_pending), 32'd0);

    // Self-address rejection
    tx_req_valid = 1'b1;
    tx_req_dest  = 4'd0;
    tx_req_data  = 24'd5;
    cyc(1);
    tx_req_valid = 1'b0;
    check("self_err",     32'(tx_req_err), 32'd1);
    check("self_pending", 32'(tx_pending), 32'd0);
    cyc(1);
    check("self_err_once", 32'(tx_req_err), 32'd0);

    // Ack timeout is sticky
    tx_exp.push_back(29'h02000007);
    push_req(4'd1, 1'b0, 24'd7);
    wait_valid("to_valid");
    cyc(200);
    check("to_not_yet", 32'(tx_timeout), 32'd0);
    cyc(100);
    check("to_set",       32'(tx_timeout),          32'd1);
    check("to_still_pre", 32'(pkt_from_node_valid), 32'd1);
    ack_pulse();
    cyc(3);
    check("to_sticky", 32'(tx_timeout), 32'd1);

    // RX level strobe yields one delivery
    rx_exp.push_back(24'd69);
    pkt_to_node       = 24'd69;
    pkt_to_node_valid = 1'b1;
    cyc(5);
    pkt_to_node_valid = 1'b0;
    cyc(1);
    check("rx_level_valid", 32'(rx_valid),    32'd1);
    check("rx_level_data",  32'(rx_data),     32'd69);
    check("rx_level_drop",  32'(rx_drop_cnt), 32'd0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check("rx_level_single", 32'(rx_valid), 32'd0);

    // RX overflow drops the third delivery
    rx_exp.push_back(24'd11);
    rx_exp.push_back(24'd22);
    deliver(24'd11);
    deliver(24'd22);
    deliver(24'd33);
    check("rx_ovf_drop", 32'(rx_drop_cnt), 32'd1);
    check("rx_ovf_head", 32'(rx_data),     32'd11);

    // RX full with simultaneous pop: no drop, new data at tail
    rx_exp.push_back(24'd44);
    pkt_to_node       = 24'd44;
    pkt_to_node_valid = 1'b1;
    rx_ready          = 1'b1;
    cyc(1);
    pkt_to_node_valid = 1'b0;
    rx_ready          = 1'b0;
    check("rx_pp_drop", 32'(rx_drop_cnt), 32'd1);
    check("rx_pp_head", 32'(rx_data),     32'd22);
    rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!rx_valid) break;
      cyc(1);
    end
    rx_ready = 1'b0;
    check("rx_drained", 32'(rx_valid), 32'd0);

    // Reset mid-transfer discards presented and queued packets
    tx_exp.push_back(29'h0A123456);
    push_req(4'd5, 1'b0, 24'h123456);
    push_req(4'd5, 1'b0, 24'h000001);
    wait_valid("mid_valid");
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_valid_low", 32'(pkt_from_node_valid), 32'd0);
    check("mid_pending",   32'(tx_pending),          32'd0);
    check("mid_timeout",   32'(tx_timeout),          32'd0);
    cyc(4);
    check("mid_no_reload", 32'(pkt_from_node_valid), 32'd0);

    check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);
    check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
